// File: rtl/tia_hcount_pkg.sv
// Shared encodings for the TIA horizontal counter: phase names, LFSR step
// function and the polynomial codes of the NTSC decode boundaries.
package tia_hcount_pkg;

    typedef enum logic [1:0] {
        PH_PHI1 = 2'd0,
        PH_PRE2 = 2'd1,
        PH_PHI2 = 2'd2,
        PH_PRE1 = 2'd3
    } phase_e;

    localparam int STEPS_NTSC = 57;

    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], ~(s[5] ^ s[4])};
    endfunction

    // Polynomial code of step n, counting updates from the all-zero state.
    function automatic logic [5:0] lfsr_of_step(input int n);
        logic [5:0] s;
        s = 6'd0;
        for (int i = 0; i < n; i++) begin
            s = lfsr_next(s);
        end
        return s;
    endfunction

    localparam logic [5:0] LFSR_WRAP         = lfsr_of_step(STEPS_NTSC - 1);
    localparam logic [5:0] LFSR_HSYNC_START  = lfsr_of_step(4);
    localparam logic [5:0] LFSR_HSYNC_END    = lfsr_of_step(8);
    localparam logic [5:0] LFSR_BURST_START  = lfsr_of_step(9);
    localparam logic [5:0] LFSR_BURST_END    = lfsr_of_step(13);
    localparam logic [5:0] LFSR_HBLANK_END   = lfsr_of_step(17);

endpackage

// File: rtl/tia_horizontal_counter_phase_gen.sv
// Divide-by-4 of the colour clock into the two step enables.
module tia_phase_gen
    import tia_hcount_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_phi1_en,
    output logic o_phi2_en,
    output logic o_phi2_next
);

    phase_e r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= PH_PHI1;
        end else begin
            r_phase <= phase_e'(r_phase + 2'd1);
        end
    end

    // phi1 is gated by reset so it stays low while the counter is held.
    assign o_phi1_en   = i_rst_n & (r_phase == PH_PHI1);
    assign o_phi2_en   = (r_phase == PH_PHI2);
    assign o_phi2_next = (r_phase == PH_PRE2);

endmodule

// File: rtl/tia_horizontal_counter.sv
// TIA horizontal sync counter: 57-state polynomial counter per line with
// HSYNC/HBLANK/colour-burst decode and RSYNC/WSYNC handling.
module tia_horizontal_counter
    import tia_hcount_pkg::*;
#(
    parameter int STEPS_PER_LINE = 57,
    parameter int HSYNC_START    = 4,
    parameter int HSYNC_END      = 8,
    parameter int BURST_START    = 9,
    parameter int BURST_END      = 13,
    parameter int HBLANK_END     = 17
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rsync,
    input  logic       i_wsync,
    output logic       o_phi1_en,
    output logic       o_phi2_en,
    output logic [5:0] o_lfsr,
    output logic       o_line_start,
    output logic       o_hsync,
    output logic       o_hblank,
    output logic       o_cburst,
    output logic       o_rdy
);

    localparam logic [5:0] L_WRAP   = lfsr_of_step(STEPS_PER_LINE - 1);
    localparam logic [5:0] L_HS_ON  = lfsr_of_step(HSYNC_START);
    localparam logic [5:0] L_HS_OFF = lfsr_of_step(HSYNC_END);
    localparam logic [5:0] L_CB_ON  = lfsr_of_step(BURST_START);
    localparam logic [5:0] L_CB_OFF = lfsr_of_step(BURST_END);
    localparam logic [5:0] L_HB_OFF = lfsr_of_step(HBLANK_END);

    logic       w_phi2_next;
    logic       w_load_zero;
    logic       w_line_start_nxt;
    logic [5:0] w_lfsr_nxt;

    logic [5:0] r_lfsr;
    logic       r_line_start;
    logic       r_hsync;
    logic       r_hblank;
    logic       r_cburst;
    logic       r_rdy;
    logic       r_rsync_pend;

    tia_phase_gen u_phase_gen (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .o_phi1_en   (o_phi1_en),
        .o_phi2_en   (o_phi2_en),
        .o_phi2_next (w_phi2_next)
    );

    // The step update is registered on the edge that opens the phi2_en cycle,
    // so lfsr, decodes and line_start change together with phi2_en; strobes
    // present in the cycle before that edge act on it.
    assign w_load_zero      = r_rsync_pend | i_rsync | (r_lfsr == L_WRAP);
    assign w_lfsr_nxt       = w_load_zero ? 6'd0 : lfsr_next(r_lfsr);
    assign w_line_start_nxt = w_phi2_next & w_load_zero;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr       <= 6'd0;
            r_line_start <= 1'b0;
            r_hsync      <= 1'b0;
            r_hblank     <= 1'b1;
            r_cburst     <= 1'b0;
            r_rsync_pend <= 1'b0;
        end else begin
            r_line_start <= w_line_start_nxt;
            if (w_phi2_next) begin
                r_lfsr       <= w_lfsr_nxt;
                r_rsync_pend <= 1'b0;
                r_hsync      <= (w_lfsr_nxt == L_HS_ON) |
                                (r_hsync & ~w_load_zero & (w_lfsr_nxt != L_HS_OFF));
                r_cburst     <= (w_lfsr_nxt == L_CB_ON) |
                                (r_cburst & ~w_load_zero & (w_lfsr_nxt != L_CB_OFF));
                r_hblank     <= w_load_zero | (r_hblank & (w_lfsr_nxt != L_HB_OFF));
            end else if (i_rsync) begin
                r_rsync_pend <= 1'b1;
            end
        end
    end

    // A line start always releases the CPU, even against a same-cycle WSYNC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdy <= 1'b1;
        end else if (w_line_start_nxt) begin
            r_rdy <= 1'b1;
        end else if (i_wsync) begin
            r_rdy <= 1'b0;
        end
    end

    assign o_lfsr       = r_lfsr;
    assign o_line_start = r_line_start;
    assign o_hsync      = r_hsync;
    assign o_hblank     = r_hblank;
    assign o_cburst     = r_cburst;
    assign o_rdy        = r_rdy;

endmodule
